mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access pipeline stage directly downstream of the execute stage. It consumes the registered ALU result (used as byte address) and the store data, and performs byte/half/word stores into an internal synchronous data memory. It returns sign- or zero-extended load data and forwards ALU result, destination register and write-enable to writeback, all aligned one cycle after the input.

Parameters:
DATA_WIDTH, 32, datapath width; fixed at 32 for byte-lane logic
DMEM_DEPTH, 256, data memory depth in 32-bit words
DMEM_ADDR, $clog2(DMEM_DEPTH), word-index width (derived, not overridable)

Ports:
i_clk  input  1  clock
i_reset_n  input  1  reset, synchronous, active-low
i_ctrl_mem_write  input  1  store this cycle
i_ctrl_mem_read  input  1  load this cycle
i_ctrl_reg_write  input  1  instruction writes rd
i_ctrl_funct3  input  3  access size/sign (RV32I load/store funct3)
i_IE_result  input  DATA_WIDTH  ALU result; byte address for loads/stores
i_IE_data_write  input  DATA_WIDTH  store data (rs2)
i_IE_rd_addr  input  5  destination register
o_MEM_read_data  output  DATA_WIDTH  extended load data
o_MEM_alu_result  output  DATA_WIDTH  registered i_IE_result
o_MEM_rd_addr  output  5  registered rd
o_MEM_reg_write  output  1  registered, qualified reg write
o_MEM_mem_to_reg  output  1  registered i_ctrl_mem_read (writeback mux select)
o_MEM_misaligned  output  1  registered misaligned-access flag

Behaviour:
- Address: byte offset = i_IE_result[1:0]. Word index = i_IE_result[DMEM_ADDR+1:2]. Upper bits are ignored, so addresses wrap modulo 4*DMEM_DEPTH.
- Misaligned when half access (funct3[1:0]=01) has offset[0]=1, or word access (funct3[1:0]=10) has offset!=0. Byte accesses are never misaligned.
- Store, when i_ctrl_mem_write=1 and the access is aligned: written at the rising edge using byte enables.
  - SB (000): data[7:0] goes to lane offset.
  - SH (001): data[15:0] goes to lanes offset, offset+1.
  - SW (010): all lanes.
  - Other funct3 values, or a misaligned access: no write.
- Load: the RAM read is synchronous. The word addressed in cycle N appears at o_MEM_read_data after the edge ending cycle N, so latency is 1 cycle. Extension is combinational on the registered raw word, using registered funct3 and offset:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001): sign-extend the selected half (offset[1] picks the half).
  - LHU (101): zero-extend the selected half.
  - LW (010) and undefined encodings: raw word.
- Pipeline: alu_result, rd_addr, mem_to_reg, misaligned, funct3 and offset are registered every cycle with 1-cycle latency, matching the RAM.
- o_MEM_reg_write = i_ctrl_reg_write & ~(i_ctrl_mem_read & misaligned), registered.
- o_MEM_misaligned asserts only when mem_read or mem_write is active.
- If mem_read and mem_write are both asserted, the store executes and mem_to_reg/reg_write are forced to 0.
- Write-first is not required. Consecutive store-then-load to the same word in back-to-back cycles returns the stored value, because the write commits at the edge before the read.
- Reset (synchronous):
  - All pipeline registers clear. o_MEM_read_data, o_MEM_alu_result, o_MEM_rd_addr, o_MEM_reg_write, o_MEM_mem_to_reg and o_MEM_misaligned all read 0 the cycle after reset is sampled.
  - Memory contents are preserved.
  - A store presented in the same cycle as reset is suppressed.
- No stall or flush inputs; every cycle advances.

Test Plan:
- SW 0xDEADBEEF at addr 0x10, then LW 0x10 next cycle -> o_MEM_read_data=0xDEADBEEF one cycle after the load; o_MEM_mem_to_reg=1.
- After the above, LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF. SH 0x1234 to 0x12 -> LW returns 0x123455EF.
- SW to 0x21 (misaligned) -> no write (LW 0x20 unchanged), o_MEM_misaligned=1. LH 0x23 with reg_write=1 -> o_MEM_reg_write=0, o_MEM_misaligned=1.
- Address wrap with DMEM_DEPTH=256: SW 0xA5A5A5A5 to 0x400 -> LW 0x000 returns 0xA5A5A5A5.
- Assert reset with a concurrent SW 0x1 to 0x10 -> no write, all outputs 0 next cycle. After deassert, LW 0x10 returns the prior contents.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte/half/word stores into a synchronous data RAM and
// extended loads, with ALU result, rd and control forwarded to writeback.
module mem_access_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int DMEM_DEPTH = 256
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_ctrl_mem_write,
   input  logic                  i_ctrl_mem_read,
   input  logic                  i_ctrl_reg_write,
   input  logic [2:0]            i_ctrl_funct3,
   input  logic [DATA_WIDTH-1:0] i_IE_result,
   input  logic [DATA_WIDTH-1:0] i_IE_data_write,
   input  logic [4:0]            i_IE_rd_addr,
   output logic [DATA_WIDTH-1:0] o_MEM_read_data,
   output logic [DATA_WIDTH-1:0] o_MEM_alu_result,
   output logic [4:0]            o_MEM_rd_addr,
   output logic                  o_MEM_reg_write,
   output logic                  o_MEM_mem_to_reg,
   output logic                  o_MEM_misaligned
);
   localparam int DMEM_ADDR = $clog2(DMEM_DEPTH);

   logic [1:0]            offset;
   logic [DMEM_ADDR-1:0]  widx;
   logic                  mis_raw, mis_act;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wdata;

   assign offset = i_IE_result[1:0];
   assign widx   = i_IE_result[DMEM_ADDR+1:2];

   always_comb begin
      case (i_ctrl_funct3[1:0])
         2'b01:   mis_raw = offset[0];
         2'b10:   mis_raw = (offset != 2'b00);
         default: mis_raw = 1'b0;
      endcase
   end

   assign mis_act = mis_raw & (i_ctrl_mem_read | i_ctrl_mem_write);

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be    = 4'b0000;
      wdata = i_IE_data_write;
      case (i_ctrl_funct3)
         3'b000: begin
            be    = 4'b0001 << offset;
            wdata = {4{i_IE_data_write[7:0]}};
         end
         3'b001: begin
            be    = 4'b0011 << {offset[1], 1'b0};
            wdata = {2{i_IE_data_write[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
      if (!i_ctrl_mem_write || mis_raw || !i_reset_n)
         be = 4'b0000;
   end

   logic [DATA_WIDTH-1:0] dmem [DMEM_DEPTH];

   // Contents survive reset; only the read register clears.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 4; i++)
         if (be[i])
            dmem[widx][8*i +: 8] <= wdata[8*i +: 8];
   end

   logic [DATA_WIDTH-1:0] raw_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         raw_q            <= '0;
         f3_q             <= '0;
         off_q            <= '0;
         o_MEM_alu_result <= '0;
         o_MEM_rd_addr    <= '0;
         o_MEM_reg_write  <= 1'b0;
         o_MEM_mem_to_reg <= 1'b0;
         o_MEM_misaligned <= 1'b0;
      end else begin
         raw_q            <= dmem[widx];
         f3_q             <= i_ctrl_funct3;
         off_q            <= offset;
         o_MEM_alu_result <= i_IE_result;
         o_MEM_rd_addr    <= i_IE_rd_addr;
         o_MEM_reg_write  <= i_ctrl_reg_write & ~(i_ctrl_mem_read & mis_act)
                             & ~(i_ctrl_mem_read & i_ctrl_mem_write);
         o_MEM_mem_to_reg <= i_ctrl_mem_read & ~i_ctrl_mem_write;
         o_MEM_misaligned <= mis_act;
      end
   end

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      case (off_q)
         2'd0:    sel_b = raw_q[7:0];
         2'd1:    sel_b = raw_q[15:8];
         2'd2:    sel_b = raw_q[23:16];
         default: sel_b = raw_q[31:24];
      endcase
      sel_h = off_q[1] ? raw_q[31:16] : raw_q[15:0];
      case (f3_q)
         3'b000:  o_MEM_read_data = {{(DATA_WIDTH-8){sel_b[7]}}, sel_b};
         3'b100:  o_MEM_read_data = {{(DATA_WIDTH-8){1'b0}}, sel_b};
         3'b001:  o_MEM_read_data = {{(DATA_WIDTH-16){sel_h[15]}}, sel_h};
         3'b101:  o_MEM_read_data = {{(DATA_WIDTH-16){1'b0}}, sel_h};
         default: o_MEM_read_data = raw_q;
      endcase
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table, reset sequence and randomized
// traffic checked against a byte-array memory model.
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_write, mem_read, reg_write;
   logic [2:0]  funct3;
   logic [31:0] ie_result, ie_data;
   logic [4:0]  ie_rd;
   logic [31:0] read_data, alu_result;
   logic [4:0]  rd_addr;
   logic        reg_write_o, mem_to_reg, misaligned;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_ctrl_mem_write(mem_write), .i_ctrl_mem_read(mem_read),
      .i_ctrl_reg_write(reg_write), .i_ctrl_funct3(funct3),
      .i_IE_result(ie_result), .i_IE_data_write(ie_data), .i_IE_rd_addr(ie_rd),
      .o_MEM_read_data(read_data), .o_MEM_alu_result(alu_result),
      .o_MEM_rd_addr(rd_addr), .o_MEM_reg_write(reg_write_o),
      .o_MEM_mem_to_reg(mem_to_reg), .o_MEM_misaligned(misaligned)
   );

   int total = 0;
   int passed = 0;
   logic [7:0] m [1024];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
   endtask

   // One pipeline step: drive, predict from the byte model, clock, compare.
   task automatic cycle(input bit rst, input bit wr, input bit rd, input bit rw,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rdst, input bit chk_data);
      int a, base, sz;
      bit mis;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] e_data, e_alu;
      logic [4:0]  e_rd;
      bit e_rw, e_m2r, e_mis;
      rst_n = ~rst; mem_write = wr; mem_read = rd; reg_write = rw;
      funct3 = f3; ie_result = addr; ie_data = wd; ie_rd = rdst;
      a    = int'(addr % 1024);
      base = a - (a % 4);
      sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      mis  = (rd || wr) && sz > 1 && (a % sz) != 0;
      b    = m[a];
      h    = {m[base + (a & 2) + 1], m[base + (a & 2)]};
      case (f3)
         3'd0: e_data = 32'($signed(b));
         3'd4: e_data = {24'h0, b};
         3'd1: e_data = 32'($signed(h));
         3'd5: e_data = {16'h0, h};
         default: e_data = {m[base+3], m[base+2], m[base+1], m[base]};
      endcase
      e_alu = addr; e_rd = rdst;
      e_m2r = rd && !wr;
      e_rw  = rw && !(rd && mis) && !(rd && wr);
      e_mis = mis;
      if (rst) begin
         e_data = 0; e_alu = 0; e_rd = 0; e_m2r = 0; e_rw = 0; e_mis = 0;
      end
      @(posedge clk);
      if (!rst && wr && !mis && f3 <= 3'd2)
         for (int k = 0; k < sz; k++) m[a + k] = wd[8*k +: 8];
      #1;
      if (chk_data) chk("read_data", read_data, e_data);
      chk("alu_result", alu_result, e_alu);
      chk("rd_addr", {27'h0, rd_addr}, {27'h0, e_rd});
      chk("reg_write", {31'h0, reg_write_o}, {31'h0, e_rw});
      chk("mem_to_reg", {31'h0, mem_to_reg}, {31'h0, e_m2r});
      chk("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
   endtask

   typedef struct {
      bit          wr, rd, rw;
      logic [2:0]  f3;
      logic [31:0] addr, wd;
      logic [4:0]  rdst;
      logic [31:0] e_data;
      bit          e_rw, e_m2r, e_mis;
   } vec_t;

   vec_t vec [19];

   initial begin
      vec[0]  = '{1,0,0,3'd2,32'h10,32'hDEADBEEF,5'd1,32'h0,0,0,0};
      vec[1]  = '{0,1,1,3'd2,32'h10,32'h0,5'd5,32'hDEADBEEF,1,1,0};
      vec[2]  = '{0,1,1,3'd0,32'h13,32'h0,5'd6,32'hFFFFFFDE,1,1,0};
      vec[3]  = '{0,1,1,3'd4,32'h13,32'h0,5'd7,32'h000000DE,1,1,0};
      vec[4]  = '{0,1,1,3'd1,32'h12,32'h0,5'd8,32'hFFFFDEAD,1,1,0};
      vec[5]  = '{0,1,1,3'd5,32'h10,32'h0,5'd9,32'h0000BEEF,1,1,0};
      vec[6]  = '{1,0,0,3'd0,32'h11,32'h55,5'd0,32'hFFFFFFBE,0,0,0};
      vec[7]  = '{0,1,1,3'd2,32'h10,32'h0,5'd10,32'hDEAD55EF,1,1,0};
      vec[8]  = '{1,0,0,3'd1,32'h12,32'h1234,5'd0,32'hFFFFDEAD,0,0,0};
      vec[9]  = '{0,1,1,3'd2,32'h10,32'h0,5'd11,32'h123455EF,1,1,0};
      vec[10] = '{1,0,0,3'd2,32'h21,32'hCAFEF00D,5'd0,32'h0,0,0,1};
      vec[11] = '{0,1,1,3'd2,32'h20,32'h0,5'd12,32'h0,1,1,0};
      vec[12] = '{0,1,1,3'd1,32'h23,32'h0,5'd13,32'h0,0,1,1};
      vec[13] = '{1,0,0,3'd2,32'h400,32'hA5A5A5A5,5'd0,32'h0,0,0,0};
      vec[14] = '{0,1,1,3'd2,32'h0,32'h0,5'd14,32'hA5A5A5A5,1,1,0};
      vec[15] = '{1,1,1,3'd2,32'h30,32'h11111111,5'd15,32'h0,0,0,0};
      vec[16] = '{0,1,1,3'd2,32'h30,32'h0,5'd16,32'h11111111,1,1,0};
      vec[17] = '{0,0,1,3'd2,32'h10,32'h0,5'd17,32'h123455EF,1,0,0};
      vec[18] = '{0,0,0,3'd1,32'h23,32'h0,5'd18,32'h0,0,0,0};

      for (int i = 0; i < 1024; i++) m[i] = 8'h00;
      rst_n = 1'b0; mem_write = 0; mem_read = 0; reg_write = 0;
      funct3 = 0; ie_result = 0; ie_data = 0; ie_rd = 0;
      @(posedge clk); #1;
      cycle(1, 0, 0, 1, 3'd2, 32'h44, 32'h0, 5'd3, 1);

      // Give the RAM known contents before any data check.
      for (int w = 0; w < 256; w++)
         cycle(0, 1, 0, 0, 3'd2, 32'(w * 4), 32'h0, 5'd0, 0);

      for (int i = 0; i < 19; i++) begin
         cycle(0, vec[i].wr, vec[i].rd, vec[i].rw, vec[i].f3, vec[i].addr,
               vec[i].wd, vec[i].rdst, 1);
         chk($sformatf("tbl%0d_data", i), read_data, vec[i].e_data);
         chk($sformatf("tbl%0d_rw", i), {31'h0, reg_write_o}, {31'h0, vec[i].e_rw});
         chk($sformatf("tbl%0d_m2r", i), {31'h0, mem_to_reg}, {31'h0, vec[i].e_m2r});
         chk($sformatf("tbl%0d_mis", i), {31'h0, misaligned}, {31'h0, vec[i].e_mis});
      end

      // Reset with a concurrent store: store dropped, outputs cleared.
      cycle(1, 1, 0, 1, 3'd2, 32'h10, 32'h1, 5'd3, 1);
      chk("rst_data", read_data, 32'h0);
      chk("rst_alu", alu_result, 32'h0);
      chk("rst_rd", {27'h0, rd_addr}, 32'h0);
      chk("rst_flags", {29'h0, reg_write_o, mem_to_reg, misaligned}, 32'h0);
      cycle(0, 0, 1, 1, 3'd2, 32'h10, 32'h0, 5'd4, 1);
      chk("post_rst_lw", read_data, 32'h123455EF);

      for (int n = 0; n < 600; n++) begin
         bit r_rst, r_wr, r_rd;
         r_rst = ($urandom_range(0, 39) == 0);
         r_wr  = ($urandom_range(0, 2) == 0);
         r_rd  = ($urandom_range(0, 1) == 0);
         cycle(r_rst, r_wr, r_rd, 1'($urandom), 3'($urandom_range(0, 7)),
               $urandom & 32'hFFFFFC3F, $urandom, 5'($urandom), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
